// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline register between two stages.
// It carries a packed payload and a packed control field with a valid/ready
// handshake, a synchronous flush, and an optional 2-entry skid buffer that
// makes in_ready a registered signal.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control-field width
//   SKID    1 = 2-entry skid buffer with registered in_ready
//           0 = single register with combinational in_ready
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high reset
//   flush         synchronous squash of every held entry
//   in_valid      upstream offers an entry
//   in_ready      this stage can take an entry this cycle
//   in_data       upstream payload
//   in_ctrl       upstream control bits
//   out_valid     output entry is valid
//   out_ready     downstream takes the output this cycle
//   out_data      registered payload
//   out_ctrl      registered control bits, forced to zero while out_valid=0
//   stall_cycles  saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_valid;
  logic              ready_int;
  logic [CNT_W-1:0]  stall_q;

  generate
    if (SKID != 0) begin : g_skid
      state_t            state;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              ready_q;

      // The main register is always the head of the queue. The skid register
      // only fills when the head is stalled and upstream still offers data,
      // because in_ready was already high for that cycle. ready_q is kept
      // equal to (state != FULL) so that upstream sees a flop, not logic.
      always_ff @(posedge clk) begin
        if (reset) begin
          state      <= EMPTY;
          main_data  <= '0;
          main_ctrl  <= '0;
          main_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
          ready_q    <= 1'b1;
        end else if (flush) begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (in_valid) begin
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
                main_valid <= 1'b1;
                state      <= ONE;
              end
            end
            ONE: begin
              if (out_ready) begin
                if (in_valid) begin
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
                end else begin
                  main_valid <= 1'b0;
                  state      <= EMPTY;
                end
              end else if (in_valid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                ready_q   <= 1'b0;
                state     <= FULL;
              end
            end
            FULL: begin
              if (out_ready) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                ready_q   <= 1'b1;
                state     <= ONE;
              end
            end
            default: begin
              state      <= EMPTY;
              main_valid <= 1'b0;
              ready_q    <= 1'b1;
            end
          endcase
        end
      end

      assign ready_int = ready_q;
    end else begin : g_direct
      // Without skid storage, the stage may accept whenever the current
      // entry leaves this cycle or there is no entry at all.
      assign ready_int = out_ready || !main_valid;

      // An input transfer always overwrites the register. An output
      // transfer with no replacement empties the stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          main_data  <= '0;
          main_ctrl  <= '0;
          main_valid <= 1'b0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_valid && ready_int) begin
          main_data  <= in_data;
          main_ctrl  <= in_ctrl;
          main_valid <= 1'b1;
        end else if (out_ready) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // This counts edges where the output is held against back-pressure.
  // The count stops at its maximum instead of wrapping. Flush does not
  // clear it; only reset does.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Gating control with valid makes an empty stage look like a NOP to
  // downstream write-enables. This holds even though main_ctrl keeps
  // stale bits after a flush.
  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign out_ctrl     = main_valid ? main_ctrl : '0;
  assign in_ready     = ready_int;
  assign stall_cycles = stall_q;

endmodule
